// File: rtl/rr_arb8_sel.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb8_sel
//  Purpose  : Eight-way round-robin arbiter driving the select and handshake
//             of an 8:1 data multiplexer stage. One source is granted at a
//             time for at most HOLD accepted beats. A grant is followed by one
//             idle cycle, and the search start point rotates past the last
//             granted source.
//  Ports    : clk_i    rising-edge clock
//             rst_i    asynchronous active-high reset
//             req_i    [7:0] per-source request
//             ready_i  downstream accepts the beat when valid_o is high
//             sel_o    [2:0] granted source index (mux select)
//             gnt_o    [7:0] one-hot grant while busy, else zero
//             valid_o  mux output beat valid
//             ack_o    [7:0] one-hot accept strobe for the granted source
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb8_sel #(
   parameter int unsigned HOLD = 4        // max beats per grant, 1..255
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] req_i,
   input  logic       ready_i,
   output logic [2:0] sel_o,
   output logic [7:0] gnt_o,
   output logic       valid_o,
   output logic [7:0] ack_o
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   localparam logic [7:0] C_LAST = 8'(HOLD - 1);

   logic [0:0] state_q, state_d;
   logic [2:0] ptr_q,   ptr_d;
   logic [7:0] cnt_q,   cnt_d;
   logic [2:0] sel_q,   sel_d;

   logic       busy_w;
   logic       beat_w;
   logic       release_w;
   logic [2:0] pick_w;
   logic [2:0] idx_w;

   assign busy_w    = (state_q == ST_BUSY);
   assign valid_o   = busy_w & req_i[sel_q];
   assign beat_w    = valid_o & ready_i;
   // Withdraw (request gone, so no beat) or final permitted beat.
   assign release_w = busy_w & (~req_i[sel_q] | (beat_w & (cnt_q == C_LAST)));

   assign sel_o = sel_q;
   assign gnt_o = busy_w ? (8'b1 << sel_q) : 8'b0;
   assign ack_o = beat_w ? gnt_o : 8'b0;

   // Rotating priority search. Scanning offsets from high to low lets the
   // lowest offset from ptr_q overwrite, so the first requester wins.
   always_comb begin
      pick_w = ptr_q;
      idx_w  = ptr_q;
      for (int k = 7; k >= 0; k--) begin
         idx_w = ptr_q + 3'(k);
         if (req_i[idx_w]) begin
            pick_w = idx_w;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      case (state_q)
         ST_IDLE: begin
            if (req_i != 8'h00) begin
               sel_d   = pick_w;
               cnt_d   = 8'h00;
               state_d = ST_BUSY;
            end
         end
         default: begin
            if (release_w) begin
               ptr_d   = sel_q + 3'd1;   // 7 wraps naturally to 0
               cnt_d   = 8'h00;
               state_d = ST_IDLE;
            end else if (beat_w) begin
               cnt_d   = cnt_q + 8'h01;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         ptr_q   <= 3'd0;
         cnt_q   <= 8'h00;
         sel_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rr_arb8_sel.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_arb8_sel
//  Purpose  : Directed self-checking bench for rr_arb8_sel. One instance with
//             HOLD=4 and one with HOLD=1 share the stimulus; each step states
//             the hand-derived busy flag, select, valid and beat for the cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rr_arb8_sel;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic       ready;

   logic [2:0] sel4, sel1;
   logic [7:0] gnt4, gnt1, ack4, ack1;
   logic       vld4, vld1;

   int errors = 0;
   int checks = 0;
   logic rst_v = 1'b1;
   int   dut_sel = 0;

   rr_arb8_sel #(.HOLD(4)) u_dut4 (
      .clk_i(clk), .rst_i(rst), .req_i(req), .ready_i(ready),
      .sel_o(sel4), .gnt_o(gnt4), .valid_o(vld4), .ack_o(ack4)
   );

   rr_arb8_sel #(.HOLD(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .req_i(req), .ready_i(ready),
      .sel_o(sel1), .gnt_o(gnt1), .valid_o(vld1), .ack_o(ack1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One cycle: drive inputs on the falling edge, then check outputs that
   // reflect the state captured on the previous rising edge.
   task automatic cyc(input logic [7:0] r, input logic rd, input logic busy,
                      input logic [2:0] s, input logic v, input logic b);
      logic [7:0] eg, ea, og, oa;
      logic [2:0] os;
      logic       ov;
      @(negedge clk);
      rst   = rst_v;
      req   = r;
      ready = rd;
      #1;
      eg = busy ? (8'b1 << s) : 8'b0;
      ea = b ? eg : 8'b0;
      if (dut_sel == 0) begin
         os = sel4; og = gnt4; ov = vld4; oa = ack4;
      end else begin
         os = sel1; og = gnt1; ov = vld1; oa = ack1;
      end
      checks++;
      assert (os === s) else begin
         errors++;
         $error("FAIL sel t=%0t observed=%0d expected=%0d", $time, os, s);
      end
      checks++;
      assert (og === eg) else begin
         errors++;
         $error("FAIL gnt t=%0t observed=%02h expected=%02h", $time, og, eg);
      end
      checks++;
      assert (ov === v) else begin
         errors++;
         $error("FAIL valid t=%0t observed=%0b expected=%0b", $time, ov, v);
      end
      checks++;
      assert (oa === ea) else begin
         errors++;
         $error("FAIL ack t=%0t observed=%02h expected=%02h", $time, oa, ea);
      end
   endtask

   initial begin
      rst = 1'b1; req = 8'h00; ready = 1'b0;

      // Reset state
      rst_v = 1'b1;
      cyc(8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      rst_v = 1'b0;

      // HOLD limit and rotation: 0..7 then wrap to 0, 4 beats each + bubble
      cyc(8'hFF, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      for (int s = 0; s < 8; s++) begin
         for (int b = 0; b < 4; b++) cyc(8'hFF, 1'b1, 1'b1, 3'(s), 1'b1, 1'b1);
         cyc(8'hFF, 1'b1, 1'b0, 3'(s), 1'b0, 1'b0);
      end
      cyc(8'hFF, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1);
      cyc(8'h00, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);   // withdraw, ptr=1
      cyc(8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

      // Backpressure: source 3, READY 1,0,0,1,1,1
      cyc(8'h08, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      cyc(8'h08, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1);
      cyc(8'h08, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0);
      cyc(8'h08, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0);
      cyc(8'h08, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1);
      cyc(8'h08, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1);
      cyc(8'h08, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1);   // 4th beat, ptr=4
      cyc(8'h00, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0);

      // Withdraw: source 5 drops after 2 beats, source 6 takes over fresh
      cyc(8'h60, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0);
      cyc(8'h60, 1'b1, 1'b1, 3'd5, 1'b1, 1'b1);
      cyc(8'h60, 1'b1, 1'b1, 3'd5, 1'b1, 1'b1);
      cyc(8'h40, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0);   // valid falls same cycle
      cyc(8'h40, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0);
      for (int b = 0; b < 4; b++) cyc(8'h40, 1'b1, 1'b1, 3'd6, 1'b1, 1'b1);
      cyc(8'h00, 1'b1, 1'b0, 3'd6, 1'b0, 1'b0);   // ptr=7

      // Source 7 alone granted after one idle cycle
      cyc(8'h80, 1'b1, 1'b0, 3'd6, 1'b0, 1'b0);
      cyc(8'h80, 1'b1, 1'b1, 3'd7, 1'b1, 1'b1);
      cyc(8'h00, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0);   // ptr=0
      // Grant 5 and withdraw to leave ptr=6
      cyc(8'h20, 1'b1, 1'b0, 3'd7, 1'b0, 1'b0);
      cyc(8'h00, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0);
      // Skip: ptr=6, REQ=21 -> 0 (wrap search), then 5
      cyc(8'h21, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0);
      for (int b = 0; b < 4; b++) cyc(8'h21, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1);
      cyc(8'h21, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      cyc(8'h21, 1'b1, 1'b1, 3'd5, 1'b1, 1'b1);
      cyc(8'h00, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0);   // ptr=6
      cyc(8'h00, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0);

      // Reset mid-grant with REQ=01
      cyc(8'h01, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0);
      cyc(8'h01, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1);
      rst_v = 1'b1;
      cyc(8'h01, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);   // async clear
      rst_v = 1'b0;
      cyc(8'hFF, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      cyc(8'hFF, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1);   // search restarted at 0
      // Reset mid-grant on a non-zero source: SEL must return to 0
      cyc(8'h04, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);   // withdraw, ptr=1
      cyc(8'h04, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      cyc(8'h04, 1'b1, 1'b1, 3'd2, 1'b1, 1'b1);
      rst_v = 1'b1;
      cyc(8'h04, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      rst_v = 1'b0;
      cyc(8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

      // HOLD=1 instance: reset, then REQ=03 alternates 0,1,0,1
      dut_sel = 1;
      rst_v = 1'b1;
      cyc(8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      rst_v = 1'b0;
      cyc(8'h03, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      cyc(8'h03, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1);
      cyc(8'h03, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      cyc(8'h03, 1'b1, 1'b1, 3'd1, 1'b1, 1'b1);
      cyc(8'h03, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0);
      cyc(8'h03, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1);
      cyc(8'h03, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      cyc(8'h03, 1'b1, 1'b1, 3'd1, 1'b1, 1'b1);
      cyc(8'h00, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
